muldiv_issue: RTL and testbench
===============================

# muldiv_issue

Issue/writeback controller between the execute stage and the multi-cycle RV32M `muldiv` unit. It accepts one M-extension operation per valid/ready handshake and registers its operands and destination. It pulses `md_start`, holds operands stable until `md_done`, and presents the result to the register-file writeback port for one cycle. It also supports pipeline flush while the divider is mid-operation.

## Interface
- No parameters.
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  execute stage presents an M-extension op
- req_ready  out  1  controller can accept; high exactly in IDLE
- req_funct3  in  3  RV32M funct3 (000 MUL … 111 REMU), forwarded unchanged as md_op
- req_rs1  in  32  rs1 value
- req_rs2  in  32  rs2 value
- req_rd  in  5  destination register
- flush  in  1  kill the in-flight op (branch/trap)
- md_start  out  1  one-cycle start pulse to muldiv
- md_op  out  3  registered funct3
- md_a  out  32  registered rs1, stable from ISSUE until muldiv done
- md_b  out  32  registered rs2, stable from ISSUE until muldiv done
- md_result  in  32  muldiv result, valid when md_done
- md_done  in  1  muldiv completion, one cycle
- md_busy  in  1  muldiv not idle
- wb_valid  out  1  writeback strobe, one cycle
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- stall  out  1  high whenever state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, WB, DRAIN. Reset state is IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid & ~flush`: latch funct3/rs1/rs2/rd, then go to ISSUE.
  - `flush` has priority over `req_valid`: the op is not accepted.
- ISSUE:
  - `md_start` = 1 if `~flush & ~md_busy`, then go to WAIT.
  - If `md_busy`: hold in ISSUE without pulsing.
  - If `flush`: no start; go to IDLE.
- WAIT:
  - On `md_done`: capture `md_result` into `wb_data`, then go to WB.
  - On `flush` without `md_done`: go to DRAIN.
  - On `flush` with `md_done`: discard the result, go to IDLE.
- WB:
  - `wb_valid` = 1 for exactly one cycle, then go to IDLE.
  - `flush` in WB does not cancel the writeback; the op is committed.
- DRAIN:
  - muldiv cannot be aborted. Wait for `md_done`, discard the result, go to IDLE.
  - `md_a`/`md_b` stay held throughout.
- rd == x0: the op executes normally and WB is visited, but `wb_valid` stays 0.
- `md_a`/`md_b`/`md_op` change only on acceptance in IDLE. muldiv samples operands after the start cycle, so they must not change earlier.
- Reset values: `req_ready` = 1. `md_start`, `md_op`, `md_a`, `md_b`, `wb_valid`, `wb_rd`, `wb_data`, `stall` all 0.
- Reset mid-operation (asserted asynchronously): return to IDLE immediately with all outputs at their reset values. muldiv is reset by the same `rst_n`.

## Timing
- Acceptance edge = cycle 0.
- `md_start` high in cycle 1.
- `wb_valid` is asserted the cycle after `md_done`.
- MUL-class ops: `md_done` in cycle 4, `wb_valid` in cycle 5.
- DIV-class ops: `md_done` in cycle 35, `wb_valid` in cycle 36.
- Back-to-back: the next request is accepted in the cycle after WB (`req_ready` is high that cycle).
- `wb_valid`, `wb_rd`, `wb_data`, `md_*` are registered outputs. `req_ready` and `stall` decode from state.

## Configuration
- Macro: `MULDIV_DIVZERO_BYPASS_EN`.
- Defined: in ISSUE, DIV/DIVU/REM/REMU resolve locally without `md_start` and go straight to WB (wb_valid in cycle 2):
  - rs2 == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
  - DIV with rs1 = 0x80000000, rs2 = 0xFFFFFFFF: result 0x80000000.
  - REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF: result 0.
- Undefined: every op goes through muldiv, and the result is whatever muldiv returns.

## Test plan
- MUL rs1 = 7, rs2 = −3 (0xFFFFFFFD), rd = 5 → `md_start` in cycle 1; `wb_valid` in cycle 5 with `wb_rd` = 5, `wb_data` = 0xFFFFFFEB.
- DIVU rs1 = 100, rs2 = 7, rd = 3 → `wb_valid` in cycle 36 with `wb_data` = 14; `stall` high in cycles 1–36; `md_a`/`md_b` constant throughout.
- REM rs1 = −7 (0xFFFFFFF9), rs2 = 2, then MULHU 0xFFFFFFFF × 0xFFFFFFFF issued back-to-back → first `wb_data` 0xFFFFFFFF, second 0xFFFFFFFE. The second request is accepted the cycle after the first WB.
- DIV accepted, `flush` in cycle 10 → enter DRAIN, no `wb_valid`. `req_ready` returns 1 the cycle after `md_done` (cycle 36).
- MUL with rd = 0 → no `wb_valid`; returns to IDLE after WB.
- With `MULDIV_DIVZERO_BYPASS_EN`: DIV rs1 = 5, rs2 = 0 → no `md_start`, `wb_valid` in cycle 2 with `wb_data` = 0xFFFFFFFF. REM 0x80000000 / 0xFFFFFFFF → `wb_data` = 0.

Source files
------------

// File: rtl/muldiv_issue.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue
// Purpose  : Issue/writeback controller between the execute stage and the
//            multi-cycle RV32M muldiv unit. Accepts one M-extension op per
//            valid/ready handshake, holds the operands for muldiv until it
//            completes, and presents the result on the writeback port for a
//            single cycle. Supports a pipeline flush at any point; a flush
//            that arrives while muldiv is running drains it before idling.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n             clock; asynchronous active-low reset
//   req_valid / req_ready  request handshake from execute (ready = IDLE)
//   req_funct3/rs1/rs2/rd  operation, operands and destination
//   flush                  kills the in-flight op
//   md_start               one-cycle start pulse to muldiv
//   md_op / md_a / md_b    registered funct3 and operands for muldiv
//   md_result/done/busy    muldiv result, completion pulse, busy flag
//   wb_valid/rd/data       register-file writeback (one-cycle strobe)
//   stall                  high whenever the controller is not idle
// Configuration:
//   MULDIV_DIVZERO_BYPASS_EN  when defined, divide-by-zero and signed
//                             overflow DIV/REM cases are resolved locally
//                             without starting muldiv.
// ============================================================================
module muldiv_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic [31:0] md_result,
  input  logic        md_done,
  input  logic        md_busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        stall
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e      state_q,    state_d;
  logic [2:0]  md_op_q,    md_op_d;
  logic [31:0] md_a_q,     md_a_d;
  logic [31:0] md_b_q,     md_b_d;
  logic [4:0]  rd_q,       rd_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q,    wb_rd_d;
  logic [31:0] wb_data_q,  wb_data_d;

  // Local resolution of the corner cases muldiv would otherwise spend the
  // full divide latency on.
  logic        byp_hit;
  logic [31:0] byp_data;

`ifdef MULDIV_DIVZERO_BYPASS_EN
  // funct3[2] = divide class, funct3[1] = remainder, funct3[0] = unsigned.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = 32'h0;
    if (md_op_q[2]) begin
      if (md_b_q == 32'h0) begin
        byp_hit  = 1'b1;
        byp_data = md_op_q[1] ? md_a_q : 32'hFFFF_FFFF;
      end else if (!md_op_q[0] && (md_a_q == 32'h8000_0000) &&
                   (md_b_q == 32'hFFFF_FFFF)) begin
        byp_hit  = 1'b1;
        byp_data = md_op_q[1] ? 32'h0 : 32'h8000_0000;
      end
    end
  end
`else
  assign byp_hit  = 1'b0;
  assign byp_data = 32'h0;
`endif

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    md_op_d    = md_op_q;
    md_a_d     = md_a_q;
    md_b_d     = md_b_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    md_start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Flush wins over a simultaneous request: nothing is accepted.
        if (req_valid && !flush) begin
          md_op_d = req_funct3;
          md_a_d  = req_rs1;
          md_b_d  = req_rs2;
          rd_d    = req_rd;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (byp_hit) begin
          state_d    = S_WB;
          wb_data_d  = byp_data;
          wb_rd_d    = rd_q;
          wb_valid_d = (rd_q != 5'd0);
        end else if (!md_busy) begin
          // Start is decoded from the state so that a flush or a busy unit in
          // this same cycle suppresses it; operands are already registered.
          md_start = 1'b1;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (md_done) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_WB;
            wb_data_d  = md_result;
            wb_rd_d    = rd_q;
            // Writes to x0 still pass through WB but never strobe.
            wb_valid_d = (rd_q != 5'd0);
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end

      // The op is committed once here; a flush no longer cancels it.
      S_WB: begin
        state_d = S_IDLE;
      end

      // muldiv cannot be aborted, so wait out its completion and drop it.
      S_DRAIN: begin
        if (md_done) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      md_op_q    <= 3'd0;
      md_a_q     <= 32'h0;
      md_b_q     <= 32'h0;
      rd_q       <= 5'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      md_op_q    <= md_op_d;
      md_a_q     <= md_a_d;
      md_b_q     <= md_b_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign req_ready = (state_q == S_IDLE);
  assign stall     = (state_q != S_IDLE);
  assign md_op     = md_op_q;
  assign md_a      = md_a_q;
  assign md_b      = md_b_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_issue
// Purpose  : Self-checking bench for muldiv_issue. A behavioural muldiv model
//            answers md_start with RV32M latency (MUL-class done 3 cycles
//            after start, DIV-class 34). Expected writebacks are queued at
//            acceptance and compared when wb_valid appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_issue;

`ifdef MULDIV_DIVZERO_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_rs1 = 32'h0;
  logic [31:0] req_rs2 = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        flush = 1'b0;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_result;
  logic        md_done;
  logic        md_busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;

  muldiv_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .flush      (flush),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_a       (md_a),
    .md_b       (md_b),
    .md_result  (md_result),
    .md_done    (md_done),
    .md_busy    (md_busy),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // RV32M reference
  function automatic logic [31:0] ref_md(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = 64'h0;
    r = 32'h0;
    case (f3)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b}; r = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'h0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 32'h0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_byp(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b);
    bit c;
    c = f3[2] && ((b == 32'h0) ||
                  (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    return BYP_EN && c;
  endfunction

  // --------------------------------------------------------------------------
  // muldiv model: result computed from the live operands at completion so
  // that any operand change during the operation corrupts the answer.
  // --------------------------------------------------------------------------
  int md_cnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                md_cnt <= 0;
    else if (md_start)         md_cnt <= md_op[2] ? 34 : 3;
    else if (md_cnt != 0)      md_cnt <= md_cnt - 1;
  end
  assign md_done   = (md_cnt == 1);
  assign md_busy   = (md_cnt != 0);
  assign md_result = md_done ? ref_md(md_op, md_a, md_b) : 32'hDEAD_BEEF;

  // --------------------------------------------------------------------------
  // Scoreboard and monitor
  // --------------------------------------------------------------------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   exp_start = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (md_start) check_eq("start_cyc", cyc, exp_start);
      if (wb_valid) begin
        if (sb.size() == 0) begin
          check_eq("wb_unexpected", {31'h0, wb_valid}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("wb_rd",  {27'h0, wb_rd}, {27'h0, mon_e.rd});
          check_eq("wb_data", wb_data, mon_e.data);
          check_eq("wb_cyc",  cyc, mon_e.cyc);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver helpers (called at a negedge, return at a negedge)
  // --------------------------------------------------------------------------
  task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp_data, input bit push,
                       output int acc);
    int n;
    int lat;
    bit byp;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("issue_timeout", {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    req_rd     = rd;
    acc        = cyc;
    byp        = is_byp(f3, a, b);
    lat        = byp ? 2 : (f3[2] ? 36 : 5);
    exp_start  = byp ? -1 : acc + 1;
    if (push && rd != 5'd0) sb.push_back('{rd, exp_data, acc + lat});
    @(negedge clk);
    req_valid  = 1'b0;
    req_rs1    = $urandom;
    req_rs2    = $urandom;
    req_rd     = 5'($urandom);
    req_funct3 = 3'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(sb.size() == 0 && req_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_eq("idle_timeout", sb.size(), 0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int          acc;
    int          acc2;
    bit          ok;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [2:0]  f3;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rrd;

    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_stall",     {31'h0, stall},     32'h0);
    check_eq("rst_md_start",  {31'h0, md_start},  32'h0);
    check_eq("rst_wb_valid",  {31'h0, wb_valid},  32'h0);
    check_eq("rst_md_ab",     md_a | md_b | {29'h0, md_op}, 32'h0);
    check_eq("rst_wb",        wb_data | {27'h0, wb_rd}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 7 * -3 -> rd 5
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1, acc);
    check_eq("mul_md_op", {29'h0, md_op}, 32'h0);
    check_eq("mul_md_a",  md_a, 32'd7);
    check_eq("mul_md_b",  md_b, 32'hFFFF_FFFD);
    wait_idle();

    // DIVU 100 / 7 with stall and operand-hold tracking, cycles 1..36
    issue(3'd5, 32'd100, 32'd7, 5'd3, 32'd14, 1'b1, acc);
    ok = 1'b1;
    a0 = md_a;
    b0 = md_b;
    for (int n = 1; n <= 36; n++) begin
      if (!stall || md_a !== a0 || md_b !== b0) ok = 1'b0;
      @(negedge clk);
    end
    check_eq("divu_stall_hold", {31'h0, ok}, 32'h1);
    check_eq("divu_md_a", a0, 32'd100);
    check_eq("divu_md_b", b0, 32'd7);
    check_eq("divu_idle_ready", {31'h0, req_ready}, 32'h1);
    check_eq("divu_idle_stall", {31'h0, stall},     32'h0);

    // REM then MULHU back-to-back
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 1'b1, acc);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, 1'b1, acc2);
    check_eq("b2b_accept_cyc", acc2, acc + 37);
    wait_idle();

    // DIV flushed in cycle 10 -> DRAIN until md_done in cycle 35
    issue(3'd4, 32'd1000, 32'd3, 5'd9, 32'd0, 1'b0, acc);
    while (cyc != acc + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    while (cyc != acc + 35) @(negedge clk);
    check_eq("drain_ready_c35", {31'h0, req_ready}, 32'h0);
    check_eq("drain_md_a",      md_a, 32'd1000);
    @(negedge clk);
    check_eq("drain_ready_c36", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);

    // MUL with rd = x0: visits WB without strobing
    issue(3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 1'b1, acc);
    while (cyc != acc + 5) @(negedge clk);
    check_eq("x0_in_wb_stall", {31'h0, stall},    32'h1);
    check_eq("x0_no_wb_valid", {31'h0, wb_valid}, 32'h0);
    @(negedge clk);
    check_eq("x0_idle_ready",  {31'h0, req_ready}, 32'h1);

    // Flush beats a request in IDLE
    req_valid = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    check_eq("flush_idle_reject", {31'h0, req_ready}, 32'h1);

    // Flush while in ISSUE: no start, back to IDLE
    issue(3'd1, 32'd5, 32'd6, 5'd10, 32'd0, 1'b0, acc);
    exp_start = -1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_issue_idle", {31'h0, req_ready}, 32'h1);
    repeat (6) @(negedge clk);

    // Divide-by-zero and signed-overflow cases (bypassed when enabled)
    issue(3'd4, 32'd5, 32'd0, 5'd4, 32'hFFFF_FFFF, 1'b1, acc);
    if (BYP_EN) check_eq("byp_no_start", {31'h0, md_start}, 32'h0);
    wait_idle();
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0, 1'b1, acc);
    wait_idle();
    issue(3'd7, 32'd77, 32'd0, 5'd11, 32'd77, 1'b1, acc);
    wait_idle();

    // Random ops against the reference
    for (int k = 0; k < 6; k++) begin
      f3  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      rrd = 5'($urandom_range(1, 31));
      issue(f3, ra, rb, rrd, ref_md(f3, ra, rb), 1'b1, acc);
      wait_idle();
    end

    // Asynchronous reset in the middle of a divide
    issue(3'd5, 32'd999, 32'd9, 5'd12, 32'd0, 1'b0, acc);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_ready", {31'h0, req_ready}, 32'h1);
    check_eq("arst_stall", {31'h0, stall},     32'h0);
    check_eq("arst_md",    md_a | md_b | {29'h0, md_op}, 32'h0);
    check_eq("arst_wb",    wb_data | {27'h0, wb_rd} | {31'h0, wb_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_start = -1;
    repeat (3) @(negedge clk);

    // A clean op after reset
    issue(3'd0, 32'd6, 32'd9, 5'd13, 32'd54, 1'b1, acc);
    wait_idle();
    check_eq("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
